// File: rtl/clb_resp_analyzer_pkg.sv
// clb_resp_analyzer_pkg: shared state encoding, MISR defaults and compare helper
package clb_resp_analyzer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] DEF_POLY = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'h00;

    function automatic logic is_mismatch(input logic s_dut, input logic co_dut,
                                         input logic s_ref, input logic co_ref);
        return (s_dut != s_ref) || (co_dut != co_ref);
    endfunction

endpackage

// File: rtl/clb_resp_analyzer_misr2.sv
// clb_resp_analyzer_misr2: SIG_W-bit MISR with 2-bit parallel input, seed load and enable
module clb_resp_analyzer_misr2 #(
    parameter int              SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY = 8'h1D,
    parameter logic [SIG_W-1:0] SEED = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic             en_i,
    input  logic [1:0]       d_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = ld_i ? SEED
              : en_i ? ({sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                        ^ {{(SIG_W-2){1'b0}}, d_i})
              : sig_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sig_q <= SEED;
        else      sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/clb_resp_analyzer.sv
// clb_resp_analyzer: compares faulty and fault-free CLB responses, counts mismatches, compacts both into MISRs
module clb_resp_analyzer
    import clb_resp_analyzer_pkg::*;
#(
    parameter int               NPAT  = 16,
    parameter int               IDX_W = 5,
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             smp_en,
    input  logic             s_dut,
    input  logic             co_dut,
    input  logic             s_ref,
    input  logic             co_ref,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] mism_cnt,
    output logic [IDX_W-1:0] first_fail,
    output logic             first_fail_vld,
    output logic [SIG_W-1:0] sig_dut,
    output logic [SIG_W-1:0] sig_ref
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] pat_idx_q, pat_idx_d, mism_q, mism_d, ff_q, ff_d;
    logic             ffv_q, ffv_d, pass_q, pass_d;
    logic             go, smp, mm;

    assign go  = start && (state_q == IDLE || state_q == DONE);
    assign smp = smp_en && state_q == RUN;
    assign mm  = smp && is_mismatch(s_dut, co_dut, s_ref, co_ref);

    always_comb begin
        state_d   = go ? RUN
                  : (smp && pat_idx_q == IDX_W'(NPAT - 1)) ? FINISH
                  : state_q == FINISH ? DONE
                  : state_q;
        pat_idx_d = go ? '0 : smp ? pat_idx_q + 1'b1 : pat_idx_q;
        mism_d    = go ? '0 : (mm && mism_q != '1) ? mism_q + 1'b1 : mism_q;
        ff_d      = go ? '0 : (mm && !ffv_q) ? pat_idx_q : ff_q;
        ffv_d     = go ? 1'b0 : ffv_q || mm;
        // Both conditions are required so MISR aliasing cannot mask a compare failure
        pass_d    = go ? 1'b0
                  : state_q == FINISH ? (mism_q == '0 && sig_dut == sig_ref)
                  : pass_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pat_idx_q <= '0;
            mism_q    <= '0;
            ff_q      <= '0;
            ffv_q     <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_idx_q <= pat_idx_d;
            mism_q    <= mism_d;
            ff_q      <= ff_d;
            ffv_q     <= ffv_d;
            pass_q    <= pass_d;
        end
    end

    clb_resp_analyzer_misr2 #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_misr_dut (
        .clk  (clk),
        .rst  (rst),
        .ld_i (go),
        .en_i (smp),
        .d_i  ({s_dut, co_dut}),
        .sig_o(sig_dut)
    );

    clb_resp_analyzer_misr2 #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_misr_ref (
        .clk  (clk),
        .rst  (rst),
        .ld_i (go),
        .en_i (smp),
        .d_i  ({s_ref, co_ref}),
        .sig_o(sig_ref)
    );

    assign busy           = state_q == RUN || state_q == FINISH;
    assign done           = state_q == DONE;
    assign pass           = pass_q;
    assign mism_cnt       = mism_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;

endmodule
